tis_exec_core: RTL and testbench

//  Parametrised TIS-100 node execution core: ACC/BAK data path, saturating ALU, program counter and jump unit in one block.

---
 rtl/tis_exec_core.sv | 197 +++++++++++++++++++
 tb/tb_tis_exec_core.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tis_exec_core.sv
// tis_exec_core: TIS-100 style node execution core.
// ACC/BAK data path, saturating (or wrapping) ALU, program counter and jump
// unit. Every neighbour port uses a blocking valid/ready handshake, and an
// instruction retires only once its port transfers have completed.
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   op, src, dst          current instruction fields for address pc
//   imm, jaddr            immediate operand, absolute jump target
//   in_data/valid/ready   per-port read channels (port i at [i*DW +: DW])
//   out_data/valid/ready  write channel; data shared, valid/ready per port
//   pc, acc, bak          architectural state
//   stalled               current instruction is waiting on a port
module tis_exec_core #(
  parameter int DW       = 11,
  parameter int NPORTS   = 4,
  parameter int PC_W     = 4,
  parameter int PROG_LEN = 15,
  parameter int SATURATE = 1,
  parameter int ACC_MAX  = 999
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           op,
  input  logic [2:0]           src,
  input  logic [2:0]           dst,
  input  logic [DW-1:0]        imm,
  input  logic [PC_W-1:0]      jaddr,
  input  logic [NPORTS*DW-1:0] in_data,
  input  logic [NPORTS-1:0]    in_valid,
  output logic [NPORTS-1:0]    in_ready,
  output logic [DW-1:0]        out_data,
  output logic [NPORTS-1:0]    out_valid,
  input  logic [NPORTS-1:0]    out_ready,
  output logic [PC_W-1:0]      pc,
  output logic [DW-1:0]        acc,
  output logic [DW-1:0]        bak,
  output logic                 stalled
);

  typedef enum logic {EXEC, WR_WAIT} state_t;
  typedef enum logic [3:0] {
    OP_NOP, OP_MOV, OP_SWP, OP_SAV, OP_ADD, OP_SUB, OP_NEG,
    OP_JMP, OP_JEZ, OP_JNZ, OP_JGZ, OP_JLZ, OP_JRO
  } op_t;

  localparam logic [2:0] SEL_ACC = 3'd4;
  localparam logic [2:0] SEL_IMM = 3'd6;
  localparam int AW = DW + 1;
  localparam int JW = DW + PC_W + 1;
  localparam logic signed [AW-1:0] SAT_P = AW'(ACC_MAX);
  localparam logic signed [AW-1:0] SAT_N = -SAT_P;
  localparam logic signed [JW-1:0] PC_MAX = JW'(PROG_LEN - 1);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DW-1:0]     acc_q, acc_d, bak_q, bak_d, out_data_q, out_data_d;
  logic [NPORTS-1:0] out_valid_q, out_valid_d;

  logic              src_port, src_vld, dst_port, reads_src, need_port, go;
  logic [DW-1:0]     src_val_port, opnd, alu_res;
  logic signed [AW-1:0] acc_x, opnd_x, alu_raw;
  logic signed [JW-1:0] jro_sum;
  logic [PC_W-1:0]   pc_inc, jtgt, jro_pc;
  logic              taken;

  // Source port select; indices at or above NPORTS never match and read as NIL.
  always_comb begin
    src_port     = 1'b0;
    src_vld      = 1'b0;
    src_val_port = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      if (32'(src) == p) begin
        src_port     = 1'b1;
        src_vld      = in_valid[p];
        src_val_port = in_data[p*DW +: DW];
      end
    end
  end

  assign dst_port  = 32'(dst) < 32'(NPORTS);
  assign reads_src = op inside {OP_MOV, OP_ADD, OP_SUB, OP_JRO};
  assign need_port = (state_q == EXEC) && reads_src && src_port;
  assign go        = (state_q == EXEC) && !(need_port && !src_vld);

  always_comb begin
    case (src)
      SEL_ACC: opnd = acc_q;
      SEL_IMM: opnd = imm;
      default: opnd = src_port ? src_val_port : '0;
    endcase
  end

  assign in_ready = (need_port && !rst) ? (NPORTS'(1) << src) : '0;
  assign stalled  = !rst && ((state_q == WR_WAIT) || (need_port && !src_vld));

  // ALU at DW+1 bits so the true result is visible before clamping/truncation.
  assign acc_x  = AW'($signed(acc_q));
  assign opnd_x = AW'($signed(opnd));
  always_comb begin
    case (op)
      OP_ADD:  alu_raw = acc_x + opnd_x;
      OP_SUB:  alu_raw = acc_x - opnd_x;
      default: alu_raw = -acc_x;
    endcase
    if (SATURATE != 0 && alu_raw > SAT_P)      alu_res = SAT_P[DW-1:0];
    else if (SATURATE != 0 && alu_raw < SAT_N) alu_res = SAT_N[DW-1:0];
    else                                       alu_res = alu_raw[DW-1:0];
  end

  assign pc_inc  = (pc_q == PC_W'(PROG_LEN - 1)) ? '0 : pc_q + PC_W'(1);
  assign jtgt    = (32'(jaddr) >= 32'(PROG_LEN)) ? '0 : jaddr;
  assign jro_sum = JW'($signed({1'b0, pc_q})) + JW'($signed(opnd));
  assign jro_pc  = jro_sum[JW-1]      ? '0 :
                   (jro_sum > PC_MAX) ? PC_W'(PROG_LEN - 1) : jro_sum[PC_W-1:0];

  always_comb begin
    case (op)
      OP_JMP:  taken = 1'b1;
      OP_JEZ:  taken = (acc_q == '0);
      OP_JNZ:  taken = (acc_q != '0);
      OP_JGZ:  taken = !acc_q[DW-1] && (acc_q != '0);
      OP_JLZ:  taken = acc_q[DW-1];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    acc_d       = acc_q;
    bak_d       = bak_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      EXEC: begin
        if (go) begin
          pc_d = pc_inc;
          case (op)
            OP_MOV: begin
              if (dst_port) begin
                out_data_d  = opnd;
                out_valid_d = NPORTS'(1) << dst;
                pc_d        = pc_q;
                state_d     = WR_WAIT;
              end else if (dst == SEL_ACC) begin
                acc_d = opnd;
              end
            end
            OP_SWP: begin
              acc_d = bak_q;
              bak_d = acc_q;
            end
            OP_SAV: bak_d = acc_q;
            OP_ADD, OP_SUB, OP_NEG: acc_d = alu_res;
            OP_JMP, OP_JEZ, OP_JNZ, OP_JGZ, OP_JLZ: if (taken) pc_d = jtgt;
            OP_JRO: pc_d = jro_pc;
            default: ;
          endcase
        end
      end
      WR_WAIT: begin
        // out_valid is one-hot on the destination port, so it doubles as the port select.
        if ((out_valid_q & out_ready) != '0) begin
          out_valid_d = '0;
          pc_d        = pc_inc;
          state_d     = EXEC;
        end
      end
      default: state_d = EXEC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EXEC;
      pc_q        <= '0;
      acc_q       <= '0;
      bak_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      bak_q       <= bak_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign pc        = pc_q;
  assign acc       = acc_q;
  assign bak       = bak_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_tis_exec_core.sv
module tb_tis_exec_core;
  localparam int DW = 11;
  localparam int NP = 4;
  localparam int PW = 4;
  localparam int PL = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]       op = '0;
  logic [2:0]       src = '0, dst = '0;
  logic [DW-1:0]    imm = '0;
  logic [PW-1:0]    jaddr = '0;
  logic [NP*DW-1:0] in_data = '0;
  logic [NP-1:0]    in_valid = '0, out_ready = '0;

  logic [NP-1:0] ir_o[2], ov_o[2];
  logic [DW-1:0] od_o[2], acc_o[2], bak_o[2];
  logic [PW-1:0] pc_o[2];
  logic          st_o[2];

  tis_exec_core #(.DW(DW), .NPORTS(NP), .PC_W(PW), .PROG_LEN(PL), .SATURATE(1), .ACC_MAX(999)) dut (
    .clk(clk), .rst(rst), .op(op), .src(src), .dst(dst), .imm(imm), .jaddr(jaddr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(ir_o[0]),
    .out_data(od_o[0]), .out_valid(ov_o[0]), .out_ready(out_ready),
    .pc(pc_o[0]), .acc(acc_o[0]), .bak(bak_o[0]), .stalled(st_o[0]));

  tis_exec_core #(.DW(DW), .NPORTS(NP), .PC_W(PW), .PROG_LEN(PL), .SATURATE(0), .ACC_MAX(999)) dutw (
    .clk(clk), .rst(rst), .op(op), .src(src), .dst(dst), .imm(imm), .jaddr(jaddr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(ir_o[1]),
    .out_data(od_o[1]), .out_valid(ov_o[1]), .out_ready(out_ready),
    .pc(pc_o[1]), .acc(acc_o[1]), .bak(bak_o[1]), .stalled(st_o[1]));

  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic signed [31:0] act, logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model, one instance per DUT (k=0 saturating, k=1 wrapping).
  int m_pc[2], m_acc[2], m_bak[2], m_od[2], m_ov[2], m_wp[2];
  bit m_wait[2];

  function automatic int s11(logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int lim(int k, int x);
    int y;
    if (k == 0) return (x > 999) ? 999 : ((x < -999) ? -999 : x);
    y = ((x % 2048) + 2048) % 2048;
    return (y >= 1024) ? y - 2048 : y;
  endfunction

  function automatic int nxt(int p);
    return (p == PL - 1) ? 0 : p + 1;
  endfunction

  function automatic int opnd(int k);
    if (int'(src) < NP) return s11(in_data[int'(src)*DW +: DW]);
    if (src == 3'd4) return m_acc[k];
    if (src == 3'd6) return s11(imm);
    return 0;
  endfunction

  function automatic bit wants_port(int k);
    bit reads = (op == 4'd1) || (op == 4'd4) || (op == 4'd5) || (op == 4'd12);
    return !m_wait[k] && reads && (int'(src) < NP);
  endfunction

  function automatic bit blocked(int k);
    return wants_port(k) && !in_valid[src];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_acc[k] = 0; m_bak[k] = 0; m_od[k] = 0; m_ov[k] = 0; m_wp[k] = 0; m_wait[k] = 0;
    end
  endtask

  task automatic model_step(int k);
    int v, t, a;
    bit tk;
    if (m_wait[k]) begin
      if (out_ready[m_wp[k]]) begin
        m_wait[k] = 0; m_ov[k] = 0; m_pc[k] = nxt(m_pc[k]);
      end
    end else if (!blocked(k)) begin
      v = opnd(k);
      t = nxt(m_pc[k]);
      case (int'(op))
        1: if (int'(dst) < NP) begin
             m_od[k] = v; m_wait[k] = 1; m_wp[k] = int'(dst); m_ov[k] = 1 << dst; t = m_pc[k];
           end else if (dst == 3'd4) m_acc[k] = v;
        2: begin a = m_acc[k]; m_acc[k] = m_bak[k]; m_bak[k] = a; end
        3: m_bak[k] = m_acc[k];
        4: m_acc[k] = lim(k, m_acc[k] + v);
        5: m_acc[k] = lim(k, m_acc[k] - v);
        6: m_acc[k] = lim(k, -m_acc[k]);
        7, 8, 9, 10, 11: begin
          tk = (op == 4'd7) || (op == 4'd8 && m_acc[k] == 0) || (op == 4'd9 && m_acc[k] != 0) ||
               (op == 4'd10 && m_acc[k] > 0) || (op == 4'd11 && m_acc[k] < 0);
          if (tk) t = (int'(jaddr) >= PL) ? 0 : int'(jaddr);
        end
        12: begin
          t = m_pc[k] + v;
          if (t < 0) t = 0;
          if (t > PL - 1) t = PL - 1;
        end
        default: ;
      endcase
      m_pc[k] = t;
    end
  endtask

  task automatic check_comb();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d in_ready", k), {28'd0, ir_o[k]}, wants_port(k) ? (1 << src) : 0);
      chk($sformatf("d%0d stalled", k), {31'd0, st_o[k]}, (m_wait[k] || blocked(k)) ? 1 : 0);
    end
  endtask

  task automatic check_regs();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d pc", k), {28'd0, pc_o[k]}, m_pc[k]);
      chk($sformatf("d%0d acc", k), $signed(acc_o[k]), m_acc[k]);
      chk($sformatf("d%0d bak", k), $signed(bak_o[k]), m_bak[k]);
      chk($sformatf("d%0d out_valid", k), {28'd0, ov_o[k]}, m_ov[k]);
      chk($sformatf("d%0d out_data", k), $signed(od_o[k]), m_od[k]);
    end
  endtask

  // Inputs are already applied; check combinational outputs, clock once, check state.
  task automatic cyc();
    #1 check_comb();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1 check_regs();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d rst pc", k), {28'd0, pc_o[k]}, 0);
      chk($sformatf("d%0d rst acc", k), $signed(acc_o[k]), 0);
      chk($sformatf("d%0d rst bak", k), $signed(bak_o[k]), 0);
      chk($sformatf("d%0d rst out_valid", k), {28'd0, ov_o[k]}, 0);
      chk($sformatf("d%0d rst in_ready", k), {28'd0, ir_o[k]}, 0);
      chk($sformatf("d%0d rst stalled", k), {31'd0, st_o[k]}, 0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_ins(int o, int s, int d, int im, int ja);
    op = 4'(o); src = 3'(s); dst = 3'(d); imm = DW'(im); jaddr = PW'(ja);
  endtask

  typedef struct {
    int op, src, dst, imm, jaddr, eacc, epc;
  } vec_t;

  vec_t tbl[23];

  initial begin
    // Expected acc/pc for the saturating core, starting from reset.
    tbl[0]  = '{4, 6, 0, 5, 0, 5, 1};
    tbl[1]  = '{4, 6, 0, 5, 0, 10, 2};
    tbl[2]  = '{4, 6, 0, 5, 0, 15, 3};
    tbl[3]  = '{5, 6, 0, 15, 0, 0, 4};
    tbl[4]  = '{8, 0, 0, 0, 3, 0, 3};
    tbl[5]  = '{9, 0, 0, 0, 9, 0, 4};
    tbl[6]  = '{1, 6, 4, 990, 0, 990, 5};
    tbl[7]  = '{4, 6, 0, 20, 0, 999, 6};
    tbl[8]  = '{10, 0, 0, 0, 5, 999, 5};
    tbl[9]  = '{12, 6, 0, -20, 0, 999, 0};
    tbl[10] = '{7, 0, 0, 0, 5, 999, 5};
    tbl[11] = '{12, 6, 0, 20, 0, 999, 14};
    tbl[12] = '{0, 0, 0, 0, 0, 999, 0};
    tbl[13] = '{3, 0, 0, 0, 0, 999, 1};
    tbl[14] = '{1, 6, 4, -990, 0, -990, 2};
    tbl[15] = '{5, 6, 0, 1000, 0, -999, 3};
    tbl[16] = '{2, 0, 0, 0, 0, 999, 4};
    tbl[17] = '{6, 0, 0, 0, 0, -999, 5};
    tbl[18] = '{11, 0, 0, 0, 15, -999, 0};
    tbl[19] = '{7, 0, 0, 0, 14, -999, 14};
    tbl[20] = '{1, 4, 5, 0, 0, -999, 0};
    tbl[21] = '{4, 5, 0, 0, 0, -999, 1};
    tbl[22] = '{13, 0, 0, 0, 0, -999, 2};

    model_reset();
    do_reset();
    for (int i = 0; i < 23; i++) begin
      set_ins(tbl[i].op, tbl[i].src, tbl[i].dst, tbl[i].imm, tbl[i].jaddr);
      cyc();
      chk($sformatf("tbl%0d acc", i), $signed(acc_o[0]), tbl[i].eacc);
      chk($sformatf("tbl%0d pc", i), {28'd0, pc_o[0]}, tbl[i].epc);
      chk($sformatf("tbl%0d stalled", i), {31'd0, st_o[0]}, 0);
    end

    // Wrapping core: 1023 + 1 -> -1024, saturating core clamps to 999.
    do_reset();
    set_ins(1, 6, 4, 1023, 0); cyc();
    set_ins(4, 6, 0, 1, 0);    cyc();
    chk("wrap add", $signed(acc_o[1]), -1024);
    chk("sat add", $signed(acc_o[0]), 999);
    set_ins(6, 0, 0, 0, 0);    cyc();
    chk("wrap neg", $signed(acc_o[1]), -1024);
    chk("sat neg", $signed(acc_o[0]), -999);

    // Blocking read from port 1.
    do_reset();
    in_data = '0;
    in_data[1*DW +: DW] = DW'(42);
    in_valid = '0; out_ready = '0;
    set_ins(1, 1, 4, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rd stalled", {31'd0, st_o[0]}, 1);
      chk("rd in_ready", {28'd0, ir_o[0]}, 2);
      chk("rd pc held", {28'd0, pc_o[0]}, 0);
    end
    in_valid = 4'b0010;
    cyc();
    chk("rd acc", $signed(acc_o[0]), 42);
    chk("rd pc", {28'd0, pc_o[0]}, 1);
    in_valid = '0;

    // Blocking write of immediate 7 to port 2.
    set_ins(1, 6, 2, 7, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("wr out_valid", {28'd0, ov_o[0]}, 4);
      chk("wr out_data", $signed(od_o[0]), 7);
      chk("wr pc held", {28'd0, pc_o[0]}, 1);
      chk("wr stalled", {31'd0, st_o[0]}, 1);
      cyc();
    end
    chk("wr out_valid late", {28'd0, ov_o[0]}, 4);
    out_ready = 4'b0100;
    cyc();
    chk("wr done valid", {28'd0, ov_o[0]}, 0);
    chk("wr done pc", {28'd0, pc_o[0]}, 2);
    out_ready = '0;

    // Reset while waiting on a write, then resume from pc 0.
    set_ins(1, 6, 0, 9, 0);
    cyc();
    chk("rw out_valid", {28'd0, ov_o[0]}, 1);
    do_reset();
    set_ins(0, 0, 0, 0, 0);
    cyc();
    chk("rw resume pc", {28'd0, pc_o[0]}, 1);
    chk("rw resume valid", {28'd0, ov_o[0]}, 0);

    // Randomized run against the model.
    for (int i = 0; i < 800; i++) begin
      op = 4'($urandom_range(0, 15));
      src = 3'($urandom_range(0, 7));
      dst = 3'($urandom_range(0, 7));
      imm = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 60)) : DW'($urandom);
      jaddr = PW'($urandom);
      in_data = {$urandom, $urandom};
      in_valid = NP'($urandom);
      out_ready = NP'($urandom);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
